// File: rtl/data_sender_pkg.sv
// rtl/data_sender_pkg.sv - shared constants and state type for the buffer read-out sender
package data_sender_pkg;

    localparam int SENDER_DATA_W = 8;
    localparam int SENDER_DEPTH  = 64;
    localparam int SENDER_RD_LAT = 2;
    localparam int SENDER_ADDR_W = $clog2(SENDER_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        SEND,
        DONE
    } sender_state_t;

endpackage

// File: rtl/data_sender_if.sv
// rtl/data_sender_if.sv - control handshake, buffer B-port read and outgoing word stream
interface data_sender_if
    import data_sender_pkg::*;
#(
    parameter int DATA_W = SENDER_DATA_W,
    parameter int ADDR_W = SENDER_ADDR_W
) ();
    logic              data_rdy;
    logic              data_done;
    logic              busy;
    logic              enable_b;
    logic [ADDR_W-1:0] dir_B;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  data_rdy, rd_data, tx_ready,
        output data_done, busy, enable_b, dir_B, tx_data, tx_valid
    );

    modport slave (
        output data_rdy, rd_data, tx_ready,
        input  data_done, busy, enable_b, dir_B, tx_data, tx_valid
    );
endinterface

// File: rtl/data_sender_rd_lat_pipe.sv
// rtl/data_sender_rd_lat_pipe.sv - valid shift register marking when buffer read data is usable
module data_sender_rd_lat_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o
);
    logic [RD_LAT-1:0] pipe_q;
    logic [RD_LAT-1:0] pipe_d;

    // Shifting left keeps this legal for RD_LAT == 1, where no older stages exist.
    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = valid_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[RD_LAT-1];
endmodule

// File: rtl/data_sender.sv
// rtl/data_sender.sv - reads the filled buffer back word by word and streams it downstream
module data_sender
    import data_sender_pkg::*;
#(
    parameter int DATA_W = SENDER_DATA_W,
    parameter int DEPTH  = SENDER_DEPTH,
    parameter int RD_LAT = SENDER_RD_LAT
) (
    input  logic          clk,
    input  logic          reset,
    data_sender_if.master bus
);
    localparam int                ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sender_state_t     state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rd_issue;
    logic              rd_strobe;

    assign rd_issue = (state_q == FETCH);

    data_sender_rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (rd_issue),
        .valid_o (rd_strobe)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.data_rdy) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_strobe) begin
                    tx_data_d  = bus.rd_data;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                // Clearing here keeps dir_B at 0 for the whole of IDLE.
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign bus.enable_b  = rd_issue;
    assign bus.dir_B     = cnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.data_done = (state_q == DONE);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
endmodule
